// File: rtl/serial_rx.sv
// RS-232 8N1 receiver: 16x phase-accumulator oversampling, mid-bit 3-sample
// majority vote, one-clock data-ready and frame-error strobes.
module serial_rx #(
    parameter int unsigned ClkFrequency          = 16000000,
    parameter int unsigned Baud                  = 115200,
    parameter int unsigned BaudGeneratorAccWidth = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       RxD,
    output logic [7:0] RxD_data,
    output logic       RxD_data_ready,
    output logic       RxD_frame_error,
    output logic       RxD_busy
);

    localparam int unsigned AccW = BaudGeneratorAccWidth + 1;
    localparam longint unsigned IncWide =
        ((64'(Baud) << (BaudGeneratorAccWidth - 3)) + (64'(ClkFrequency) >> 8))
        / (64'(ClkFrequency) >> 7);
    localparam logic [AccW-1:0] Inc = AccW'(IncWide);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

    state_e          state_q, state_d;
    logic [1:0]      sync_q, sync_d;
    logic [AccW-1:0] acc_q, acc_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [2:0]      bitcnt_q, bitcnt_d;
    logic [7:0]      shift_q, shift_d;
    logic [1:0]      samp_q, samp_d;
    logic [7:0]      data_q, data_d;
    logic            ready_q, ready_d;
    logic            ferr_q, ferr_d;
    logic            busy_q, busy_d;

    logic       rxd_s;
    logic       tick;
    logic [2:0] vote;
    logic       maj;

    assign rxd_s = sync_q[1];
    assign tick  = acc_q[AccW-1];

    // Samples from cnt=7 and cnt=8 are held; the cnt=9 sample is the live rxd_s.
    assign vote = {samp_q, rxd_s};
    assign maj  = (vote[2] & vote[1]) | (vote[2] & vote[0]) | (vote[1] & vote[0]);

    always_comb begin
        sync_d   = {sync_q[0], RxD};
        acc_d    = AccW'(acc_q[AccW-2:0]) + Inc;
        state_d  = state_q;
        cnt_d    = cnt_q;
        bitcnt_d = bitcnt_q;
        shift_d  = shift_q;
        samp_d   = samp_q;
        data_d   = data_q;
        ready_d  = 1'b0;
        ferr_d   = 1'b0;

        if (tick) begin
            if (state_q != IDLE) begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd7 || cnt_q == 4'd8) begin
                    samp_d = {samp_q[0], rxd_s};
                end
            end

            case (state_q)
                IDLE: begin
                    // Detection tick counts as sample 0 of the start bit.
                    if (!rxd_s) begin
                        state_d = START;
                        cnt_d   = 4'd1;
                    end
                end
                START: begin
                    if (cnt_q == 4'd9 && maj) begin
                        state_d = IDLE;
                    end else if (cnt_q == 4'd15) begin
                        state_d  = DATA;
                        bitcnt_d = 3'd0;
                    end
                end
                DATA: begin
                    if (cnt_q == 4'd9) begin
                        shift_d = {maj, shift_q[7:1]};
                    end
                    if (cnt_q == 4'd15) begin
                        if (bitcnt_q == 3'd7) begin
                            state_d = STOP;
                        end else begin
                            bitcnt_d = bitcnt_q + 3'd1;
                        end
                    end
                end
                STOP: begin
                    // Leave at mid-stop-bit so a start bit right after one stop bit is caught.
                    if (cnt_q == 4'd9) begin
                        if (maj) begin
                            data_d  = shift_q;
                            ready_d = 1'b1;
                        end else begin
                            ferr_d = 1'b1;
                        end
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            sync_q   <= 2'b11;
            acc_q    <= '0;
            cnt_q    <= 4'd0;
            bitcnt_q <= 3'd0;
            shift_q  <= 8'h00;
            samp_q   <= 2'b00;
            data_q   <= 8'h00;
            ready_q  <= 1'b0;
            ferr_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sync_q   <= sync_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            bitcnt_q <= bitcnt_d;
            shift_q  <= shift_d;
            samp_q   <= samp_d;
            data_q   <= data_d;
            ready_q  <= ready_d;
            ferr_q   <= ferr_d;
            busy_q   <= busy_d;
        end
    end

    assign RxD_data        = data_q;
    assign RxD_data_ready  = ready_q;
    assign RxD_frame_error = ferr_q;
    assign RxD_busy        = busy_q;

endmodule

// File: tb/tb_serial_rx.sv
// Scoreboard bench for serial_rx: frames are driven bit-serially, expected
// bytes queued at send time and checked when the ready strobe appears.
module tb_serial_rx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       RxD = 1'b1;
    logic [7:0] RxD_data;
    logic       RxD_data_ready;
    logic       RxD_frame_error;
    logic       RxD_busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int ready_count = 0;
    int fe_count    = 0;
    int last_ready_cyc = 0;
    int tx_start_cyc   = 0;
    logic prev_ready = 1'b0;
    logic prev_fe    = 1'b0;
    logic [7:0] sb[$];

    serial_rx dut (
        .clk             (clk),
        .rst             (rst),
        .RxD             (RxD),
        .RxD_data        (RxD_data),
        .RxD_data_ready  (RxD_data_ready),
        .RxD_frame_error (RxD_frame_error),
        .RxD_busy        (RxD_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input int bt, input logic stop_bit);
        @(posedge clk);
        #1;
        tx_start_cyc = cyc;
        RxD = 1'b0;
        wait_clks(bt);
        for (int i = 0; i < 8; i++) begin
            RxD = b[i];
            wait_clks(bt);
        end
        RxD = stop_bit;
        wait_clks(bt);
        RxD = 1'b1;
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        #1;
        check_eq("sb_drain", 32'(sb.size()), 32'd0);
    endtask

    // Output monitor: pops the scoreboard on every ready strobe.
    always @(negedge clk) begin
        logic [7:0] exp_b;
        if (RxD_data_ready) begin
            ready_count++;
            last_ready_cyc = cyc;
            check_eq("ready_pulse_width", 32'(prev_ready), 32'd0);
            check_eq("strobe_exclusive", 32'(RxD_frame_error), 32'd0);
            if (sb.size() == 0) begin
                check_eq("sb_pending", 32'(sb.size()), 32'd1);
            end else begin
                exp_b = sb.pop_front();
                check_eq("rx_data", 32'(RxD_data), 32'(exp_b));
            end
        end
        if (RxD_frame_error) begin
            fe_count++;
            check_eq("ferr_pulse_width", 32'(prev_fe), 32'd0);
        end
        prev_ready = RxD_data_ready;
        prev_fe    = RxD_frame_error;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        int lat;
        int rc;
        int fe0;
        int n;

        // 1: reset and idle line
        rst = 1'b1;
        RxD = 1'b1;
        wait_clks(2);
        check_eq("rst_busy", 32'(RxD_busy), 32'd0);
        check_eq("rst_data", 32'(RxD_data), 32'd0);
        wait_clks(3);
        rst = 1'b0;
        wait_clks(2000);
        check_eq("idle_data", 32'(RxD_data), 32'd0);
        check_eq("idle_ready", 32'(RxD_data_ready), 32'd0);
        check_eq("idle_ferr", 32'(RxD_frame_error), 32'd0);
        check_eq("idle_busy", 32'(RxD_busy), 32'd0);
        check_eq("idle_ready_count", 32'(ready_count), 32'd0);
        check_eq("idle_fe_count", 32'(fe_count), 32'd0);

        // 2: nominal 0x55 and ready latency from the start edge
        sb.push_back(8'h55);
        send_frame(8'h55, 139, 1'b1);
        wait_drain(3000);
        lat = last_ready_cyc - tx_start_cyc;
        check_eq($sformatf("latency_%0d_window", lat), 32'(lat >= 1299 && lat <= 1345), 32'd1);
        check_eq("t2_ready_count", 32'(ready_count), 32'd1);
        check_eq("t2_fe_count", 32'(fe_count), 32'd0);

        // 3: back-to-back at +3% then -3% baud
        sb.push_back(8'hA5);
        sb.push_back(8'h3C);
        send_frame(8'hA5, 135, 1'b1);
        send_frame(8'h3C, 143, 1'b1);
        wait_drain(3000);
        check_eq("t3_ready_count", 32'(ready_count), 32'd3);
        check_eq("t3_fe_count", 32'(fe_count), 32'd0);

        // 4: 20-clk glitch is a false start
        rc = ready_count;
        @(posedge clk);
        #1;
        RxD = 1'b0;
        wait_clks(20);
        RxD = 1'b1;
        check_eq("glitch_busy_rise", 32'(RxD_busy), 32'd1);
        n = 0;
        while (RxD_busy && n < 139) begin
            wait_clks(1);
            n++;
        end
        check_eq("glitch_busy_fall", 32'(RxD_busy), 32'd0);
        wait_clks(200);
        check_eq("glitch_ready_count", 32'(ready_count), 32'(rc));
        check_eq("glitch_data", 32'(RxD_data), 32'h3C);
        check_eq("glitch_fe_count", 32'(fe_count), 32'd0);

        // 5: good byte, then a frame with stop bit low
        sb.push_back(8'h12);
        send_frame(8'h12, 139, 1'b1);
        wait_drain(3000);
        fe0 = fe_count;
        rc  = ready_count;
        send_frame(8'hFF, 139, 1'b0);
        wait_clks(600);
        check_eq("ferr_count", 32'(fe_count), 32'(fe0 + 1));
        check_eq("ferr_no_ready", 32'(ready_count), 32'(rc));
        check_eq("ferr_data_kept", 32'(RxD_data), 32'h12);
        check_eq("ferr_busy_idle", 32'(RxD_busy), 32'd0);

        // 6: async reset during data bit 3 of 0xF0, then 0x81
        rc = ready_count;
        @(posedge clk);
        #1;
        RxD = 1'b0;
        wait_clks(139 * 4 + 70);
        #3;
        rst = 1'b1;
        #1;
        check_eq("abort_busy", 32'(RxD_busy), 32'd0);
        check_eq("abort_ready", 32'(RxD_data_ready), 32'd0);
        check_eq("abort_data", 32'(RxD_data), 32'd0);
        RxD = 1'b1;
        wait_clks(3);
        rst = 1'b0;
        wait_clks(50);
        check_eq("abort_no_strobe", 32'(ready_count), 32'(rc));
        sb.push_back(8'h81);
        send_frame(8'h81, 139, 1'b1);
        wait_drain(3000);
        check_eq("t6_ready_count", 32'(ready_count), 32'(rc + 1));
        check_eq("t6_data", 32'(RxD_data), 32'h81);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
